// File: rtl/mem_fill_responder.sv
// mem_fill_responder
//   Memory-side responder shared by the I-cache and D-cache. It arbitrates
//   D-cache write-through stores, D-cache fills and I-cache fills. It issues
//   block fills to a fixed-latency pipelined memory. Returned words are passed
//   straight through, tagged with their word index within the block.
//
//   Ports
//     clk, rst_n                  clock (rising edge), async active-low reset
//     ic_req / ic_addr            I-cache fill request (held until its fill_done)
//     dc_req / dc_addr            D-cache fill request (held until its fill_done)
//     dc_wr_req / _addr / _data   D-cache store (held until wr_ack)
//     ic_grant / dc_grant         transaction in progress for that cache
//     fill_valid / fill_data /    returned word, its index and destination
//       fill_word / fill_dst
//     fill_done                   pulse with the last word of a block
//     wr_ack                      pulse in the cycle the store is issued
//     mem_en / mem_wr / mem_addr  memory command (addr/wdata are 0 when idle)
//       / mem_wdata
//     mem_rdata / mem_rvalid      memory read return
module mem_fill_responder #(
  parameter int unsigned MEM_LAT     = 4,
  parameter int unsigned BLOCK_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ic_req,
  input  logic [15:0]                    ic_addr,
  input  logic                           dc_req,
  input  logic [15:0]                    dc_addr,
  input  logic                           dc_wr_req,
  input  logic [15:0]                    dc_wr_addr,
  input  logic [15:0]                    dc_wr_data,
  output logic                           ic_grant,
  output logic                           dc_grant,
  output logic                           fill_valid,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           fill_dst,
  output logic                           fill_done,
  output logic                           wr_ack,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [15:0]                    mem_addr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata,
  input  logic                           mem_rvalid
);

  localparam int unsigned WW  = $clog2(BLOCK_WORDS);
  // One extra bit so the issue counter can express "all words issued".
  localparam int unsigned CW  = WW + 1;
  localparam logic [CW-1:0] BW_C   = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] LAST_C = CW'(BLOCK_WORDS - 1);

  // The design itself never counts latency: data is accepted whenever
  // mem_rvalid arrives. A latency below one cycle cannot be supported.
  if (MEM_LAT < 1) begin : g_mem_lat_invalid
    $error("mem_fill_responder: MEM_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FILL  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          dst_q, dst_d;       // 0 = I-cache, 1 = D-cache
  logic [15:0]   addr_q, addr_d;     // block base for fills, byte address for stores
  logic [15:0]   wdata_q, wdata_d;
  logic [CW-1:0] issue_cnt_q, issue_cnt_d;
  logic [CW-1:0] rcv_cnt_q, rcv_cnt_d;

  // State and captured-request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dst_q       <= 1'b0;
      addr_q      <= 16'h0000;
      wdata_q     <= 16'h0000;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
    end
  end

  // Arbitration, memory command generation and fill return steering.
  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;

    ic_grant   = 1'b0;
    dc_grant   = 1'b0;
    fill_valid = 1'b0;
    fill_data  = 16'h0000;
    fill_word  = '0;
    fill_dst   = 1'b0;
    fill_done  = 1'b0;
    wr_ack     = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;

    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        rcv_cnt_d   = '0;
        // Stores win so write-through data reaches memory before any refill.
        if (dc_wr_req) begin
          state_d = WRITE;
          dst_d   = 1'b1;
          addr_d  = dc_wr_addr;
          wdata_d = dc_wr_data;
        end else if (dc_req) begin
          state_d = FILL;
          dst_d   = 1'b1;
          addr_d  = dc_addr & 16'hFFF0;
        end else if (ic_req) begin
          state_d = FILL;
          dst_d   = 1'b0;
          addr_d  = ic_addr & 16'hFFF0;
        end else begin
          state_d = IDLE;
        end
      end

      WRITE: begin
        dc_grant  = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        wr_ack    = 1'b1;
        state_d   = IDLE;
      end

      FILL: begin
        ic_grant = ~dst_q;
        dc_grant = dst_q;
        if (issue_cnt_q < BW_C) begin
          mem_en      = 1'b1;
          mem_addr    = addr_q + {{(16 - CW - 1){1'b0}}, issue_cnt_q, 1'b0};
          issue_cnt_d = issue_cnt_q + CW'(1);
        end else begin
          mem_en = 1'b0;
        end
        // Returns may overlap the issue stream when the latency is short;
        // only the receive counter orders the words handed back.
        if (mem_rvalid) begin
          fill_valid = 1'b1;
          fill_data  = mem_rdata;
          fill_word  = rcv_cnt_q[WW-1:0];
          fill_dst   = dst_q;
          if (rcv_cnt_q == LAST_C) begin
            fill_done = 1'b1;
            state_d   = IDLE;
          end else begin
            rcv_cnt_d = rcv_cnt_q + CW'(1);
          end
        end else begin
          fill_valid = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
